// File: rtl/srambank_req_ctrl.sv
// Request sequencer for one synchronous SRAM bank: clears the bank,
// issues one read or write per clock and returns read data through a credited FIFO.
module srambank_req_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 74,
    parameter int                RSP_DEPTH = 2,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              init_start,
    output logic              init_done,
    output logic              sram_banksel,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wd,
    input  logic [DATA_W-1:0] sram_dataout
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {INIT, IDLE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              rd_pending;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       used;
    logic              push, pop, credit_ok;
    logic              bank_sel, bank_rd, bank_wr;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wd;

    assign push      = rd_pending;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_valid = (count != '0);
    assign rsp_rdata = fifo_mem[rd_ptr];

    // A slot freed by this cycle's pop can be reused by a read issued now.
    assign used      = {1'b0, count} + {{CW{1'b0}}, rd_pending} - {{CW{1'b0}}, pop};
    assign credit_ok = (used < (CW+1)'(RSP_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT:  if (cnt == '1)  state_nxt = IDLE;
            IDLE:  if (init_start) state_nxt = DRAIN;
            DRAIN: if (!rd_pending) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        bank_sel  = 1'b0;
        bank_rd   = 1'b0;
        bank_wr   = 1'b0;
        bank_addr = '0;
        bank_wd   = '0;
        unique case (state)
            INIT: begin
                bank_sel  = 1'b1;
                bank_wr   = 1'b1;
                bank_addr = cnt;
                bank_wd   = INIT_VAL;
            end
            IDLE: begin
                init_done = 1'b1;
                if (!init_start) req_ready = req_write | credit_ok;
                if (req_valid && req_ready) begin
                    bank_sel  = 1'b1;
                    bank_addr = req_addr;
                    if (req_write) begin
                        bank_wr = 1'b1;
                        bank_wd = req_wdata;
                    end else begin
                        bank_rd = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // The bank must be quiet while reset is held, even though the state is INIT.
    assign sram_banksel = bank_sel & rst_n;
    assign sram_read    = bank_rd & rst_n;
    assign sram_write   = bank_wr & rst_n;
    assign sram_addr    = rst_n ? bank_addr : '0;
    assign sram_wd      = rst_n ? bank_wd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rd_pending <= 1'b0;
        end else begin
            cnt        <= (state == INIT) ? cnt + 1'b1 : '0;
            rd_pending <= bank_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sram_dataout;
    end

endmodule

// File: tb/tb_srambank_req_ctrl.sv
// Directed bench for srambank_req_ctrl with a behavioural
// registered-output SRAM bank attached to the sram_* pins.
module tb_srambank_req_ctrl;

    localparam int AW = 8;
    localparam int DW = 74;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_start, init_done;
    logic          sram_banksel, sram_read, sram_write;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wd, sram_dataout;

    logic [DW-1:0] bank [256];
    logic [DW-1:0] bank_q;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_banksel) begin
            if (sram_write) bank[sram_addr] <= sram_wd;
            if (sram_read)  bank_q <= bank[sram_addr];
        end
    end
    assign sram_dataout = bank_q;

    srambank_req_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .init_start   (init_start),
        .init_done    (init_done),
        .sram_banksel (sram_banksel),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_addr    (sram_addr),
        .sram_wd      (sram_wd),
        .sram_dataout (sram_dataout)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int i);
        return {2'b10, 8'(i), 64'hDEAD_BEEF_0000_0000 + 64'(i)};
    endfunction

    task automatic drive(input logic v, input logic w, input int a, input logic [DW-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = AW'(a);
        req_wdata = d;
    endtask

    // One clear cycle per iteration, checked just after each falling edge.
    task automatic clear_run(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            #1;
            check("clear",
                  {init_done, req_ready, sram_banksel, sram_read, sram_write, sram_addr, sram_wd},
                  {5'b00101, 8'(start + i), {DW{1'b0}}});
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        init_start = 1'b0;
        drive(0, 0, 0, '0);
        #2;
        check("rst_out",
              {init_done, req_ready, rsp_valid, sram_banksel, sram_read, sram_write, sram_addr, sram_wd},
              '0);

        @(negedge clk);
        rst_n = 1'b1;
        clear_run(256, 0);
        #1;
        check("idle_after_clear", {init_done, req_ready, rsp_valid}, 3'b110);
        @(negedge clk);

        // write 7 then read 7 on the next cycle
        drive(1, 1, 7, 74'h3A5);
        #1;
        check("wr_ready", req_ready, 1'b1);
        check("wr_pins", {sram_banksel, sram_read, sram_write, sram_addr, sram_wd}, {3'b101, 8'd7, 74'h3A5});
        @(negedge clk);
        drive(1, 0, 7, '0);
        #1;
        check("rd_pins", {req_ready, sram_banksel, sram_read, sram_write, sram_addr}, {4'b1110, 8'd7});
        @(negedge clk);
        drive(0, 0, 0, '0);
        #1;
        check("rsp_not_yet", {rsp_valid, sram_banksel, sram_read, sram_write}, 4'b0000);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("raw_valid", rsp_valid, 1'b1);
        check("raw_data", rsp_rdata, 74'h3A5);
        @(negedge clk);
        #1;
        check("raw_popped", rsp_valid, 1'b0);
        @(negedge clk);

        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, i, val(i));
            #1;
            check("fill_ready", req_ready, 1'b1);
            @(negedge clk);
        end

        // back-to-back reads, responses every cycle
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, i, '0);
            #1;
            check("b2b_ready", req_ready, 1'b1);
            if (i >= 3) check("b2b_rsp", {rsp_valid, rsp_rdata}, {1'b1, val(i - 2)});
            @(negedge clk);
        end
        drive(0, 0, 0, '0);
        #1;
        check("b2b_rsp3", {rsp_valid, rsp_rdata}, {1'b1, val(3)});
        @(negedge clk);
        #1;
        check("b2b_rsp4", {rsp_valid, rsp_rdata}, {1'b1, val(4)});
        @(negedge clk);
        #1;
        check("b2b_empty", rsp_valid, 1'b0);
        @(negedge clk);

        // backpressure: two credits, third read stalls
        rsp_ready = 1'b0;
        drive(1, 0, 1, '0);
        #1;
        check("bp_rd1", req_ready, 1'b1);
        @(negedge clk);
        drive(1, 0, 2, '0);
        #1;
        check("bp_rd2", req_ready, 1'b1);
        @(negedge clk);
        drive(1, 0, 3, '0);
        #1;
        check("bp_stall", {req_ready, sram_banksel, sram_read, sram_write}, 4'b0000);
        check("bp_head", {rsp_valid, rsp_rdata}, {1'b1, val(1)});
        @(negedge clk);
        #1;
        check("bp_stall2", req_ready, 1'b0);
        check("bp_hold", {rsp_valid, rsp_rdata}, {1'b1, val(1)});
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_release", {req_ready, sram_banksel, sram_read, sram_write}, 4'b1110);
        check("bp_pop1", rsp_rdata, val(1));
        @(negedge clk);
        drive(0, 0, 0, '0);
        #1;
        check("bp_pop2", {rsp_valid, rsp_rdata}, {1'b1, val(2)});
        @(negedge clk);
        #1;
        check("bp_pop3", {rsp_valid, rsp_rdata}, {1'b1, val(3)});
        @(negedge clk);
        #1;
        check("bp_empty", rsp_valid, 1'b0);
        @(negedge clk);

        // re-clear with one read in flight
        drive(1, 0, 7, '0);
        #1;
        check("pre_init_rd", req_ready, 1'b1);
        @(negedge clk);
        drive(1, 1, 7, 74'h123);
        init_start = 1'b1;
        #1;
        check("init_blocks", {init_done, req_ready, sram_banksel, sram_read, sram_write}, 5'b10000);
        @(negedge clk);
        init_start = 1'b0;
        drive(0, 0, 0, '0);
        #1;
        check("drain", {init_done, req_ready, sram_banksel, sram_write}, 4'b0000);
        check("drain_rsp", {rsp_valid, rsp_rdata}, {1'b1, 74'h3A5});
        @(negedge clk);
        clear_run(256, 0);
        #1;
        check("reinit_done", {init_done, rsp_valid}, 2'b10);
        drive(1, 0, 7, '0);
        #1;
        check("post_init_rd", req_ready, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, '0);
        @(negedge clk);
        #1;
        check("post_init_val", {rsp_valid, rsp_rdata}, {1'b1, {DW{1'b0}}});
        @(negedge clk);

        // reset in the middle of a clear, with a response still queued
        rsp_ready = 1'b0;
        drive(1, 0, 5, '0);
        #1;
        check("mid_rd", req_ready, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, '0);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        #1;
        check("mid_drain", {init_done, rsp_valid}, 2'b01);
        @(negedge clk);
        clear_run(100, 0);
        #1;
        check("at_100", {sram_write, sram_addr}, {1'b1, 8'd100});
        rst_n = 1'b0;
        #1;
        check("mid_rst",
              {init_done, req_ready, rsp_valid, sram_banksel, sram_read, sram_write, sram_addr, sram_wd},
              '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_run(256, 0);
        #1;
        check("final_idle", {init_done, req_ready, rsp_valid}, 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
